serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_ctrl_pkg.sv | 50 +++++
 rtl/serial_alu_ctrl_if.sv | 25 ++
 rtl/serial_alu_ctrl_bit_alu.sv | 31 +++
 rtl/serial_alu_ctrl.sv | 113 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: alu_ctl codes, FSM
// states, slice operation encodings and the alu_ctl -> slice control decode.
package serial_alu_ctrl_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SET  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // The slice also implements 2'b11 (pass "less"), which this controller never selects.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10
    } slice_op_e;

    typedef struct packed {
        logic      ainv;
        logic      binv;
        slice_op_e op;
        logic      valid;
        logic      slt;
        logic      arith;
    } slice_ctl_t;

    function automatic slice_ctl_t decode_ctl(input logic [3:0] ctl);
        slice_ctl_t c;
        c = '{ainv: 1'b0, binv: 1'b0, op: OP_AND, valid: 1'b1, slt: 1'b0, arith: 1'b0};
        case (ctl)
            CTL_AND: c.op = OP_AND;
            CTL_OR:  c.op = OP_OR;
            CTL_ADD: begin c.op = OP_ADD; c.arith = 1'b1; end
            CTL_SUB: begin c.op = OP_ADD; c.binv = 1'b1; c.arith = 1'b1; end
            CTL_SLT: begin c.op = OP_ADD; c.binv = 1'b1; c.slt = 1'b1; end
            CTL_NOR: begin c.op = OP_AND; c.ainv = 1'b1; c.binv = 1'b1; end
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle of the serial ALU: the requester drives the
// operation and operands, the ALU returns status and the registered result.
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output start, alu_ctl, a, b,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, alu_ctl, a, b,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/serial_alu_ctrl_bit_alu.sv
// Classic 1-bit ALU slice: optional operand inversion, full adder, and a
// 4:1 select between AND, OR, SUM and the external "less" input.
module bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic       ainv,
    input  logic       binv,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout
);
    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ ainv;
    assign b_eff = b ^ binv;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        res = less;
        case (op)
            2'b00:   res = a_eff & b_eff;
            2'b01:   res = a_eff | b_eff;
            2'b10:   res = a_eff ^ b_eff ^ cin;
            default: res = less;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU: one bit per clock through a single slice, LSB first; the
// result, zero and overflow registers update only when an operation completes.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    serial_alu_ctrl_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, work_q, work_d, result_q;
    logic [3:0]       ctl_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, slt_q, zero_q, ovf_q;
    logic             slice_res, slice_cout, last_bit;
    logic             busy, done;
    slice_ctl_t       dec;

    assign dec      = decode_ctl(ctl_q);
    assign last_bit = (idx_q == IW'(WIDTH - 1));

    bit_alu u_bit_alu (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .ainv (dec.ainv),
        .binv (dec.binv),
        .cin  (carry_q),
        .less (1'b0),
        .op   (dec.op),
        .res  (slice_res),
        .cout (slice_cout)
    );

    // Working word with the current bit merged in; undefined codes and SLT contribute zeros.
    always_comb begin
        work_d        = work_q;
        work_d[idx_q] = slice_res & dec.valid & ~dec.slt;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = dec.slt ? ST_SET : ST_DONE;
            ST_SET:  state_d = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: operand and work registers have no reset; they are always loaded before they are read.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            ctl_q  <= bus.alu_ctl;
            work_q <= '0;
        end else if (state_q == ST_RUN) begin
            work_q <= work_d;
            if (last_bit) slt_q <= slice_res ^ carry_q ^ slice_cout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    idx_q   <= '0;
                    carry_q <= decode_ctl(bus.alu_ctl).binv;
                end
                ST_RUN: begin
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (last_bit && !dec.slt) begin
                        result_q <= work_d;
                        zero_q   <= (work_d == '0);
                        ovf_q    <= dec.arith & (carry_q ^ slice_cout);
                    end
                end
                ST_SET: begin
                    result_q <= {{(WIDTH - 1){1'b0}}, slt_q};
                    zero_q   <= ~slt_q;
                    ovf_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl (WIDTH=32): inputs change on the falling
// edge, outputs are sampled on the falling edge, latency counted in cycles.
module tb_serial_alu_ctrl;
    import serial_alu_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          output logic [W-1:0] res, output logic z, output logic ov,
                          output int lat, output logic done_next);
        bus.start = 1'b1; bus.alu_ctl = ctl; bus.a = ai; bus.b = bi;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~ai; bus.b = ~bi;
        lat = -1; res = '0; z = 1'b0; ov = 1'b0; done_next = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n; res = bus.result; z = bus.zero; ov = bus.overflow;
                break;
            end
        end
        @(negedge clk);
        done_next = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.alu_ctl = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", bus.zero); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        run_op(CTL_ADD, 32'h7FFF_FFFF, 32'h1, r, z, ov, lat, dn);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got %h want 80000000", r); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL add_ovf_flag got %b want 1", ov); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_ovf_zero got %b want 0", z); end
        checks++; if (lat != 33) begin errors++; $display("FAIL add_latency got %0d want 33", lat); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0 next cycle", dn); end
        checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL add_result_hold got %h want 80000000", bus.result); end
        run_op(CTL_ADD, 32'hFFFF_FFFF, 32'h2, r, z, ov, lat, dn);
        checks++; if (r !== 32'h1 || ov !== 1'b0) begin errors++; $display("FAIL add_wrap got %h/%b want 00000001/0", r, ov); end
    endtask

    task automatic test_sub();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        run_op(CTL_SUB, 32'h5, 32'h5, r, z, ov, lat, dn);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL sub_eq_result got %h want 0", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_eq_zero got %b want 1", z); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL sub_eq_ovf got %b want 0", ov); end
        run_op(CTL_SUB, 32'h0, 32'h1, r, z, ov, lat, dn);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_neg_result got %h want ffffffff", r); end
        checks++; if (ov !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL sub_neg_flags got ovf %b zero %b want 0 0", ov, z); end
        run_op(CTL_SUB, 32'h8000_0000, 32'h1, r, z, ov, lat, dn);
        checks++; if (r !== 32'h7FFF_FFFF || ov !== 1'b1) begin errors++; $display("FAIL sub_ovf got %h/%b want 7fffffff/1", r, ov); end
    endtask

    task automatic test_slt();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        run_op(CTL_SLT, 32'h8000_0000, 32'h1, r, z, ov, lat, dn);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL slt_true_result got %h want 1", r); end
        checks++; if (lat != 34) begin errors++; $display("FAIL slt_latency got %0d want 34", lat); end
        checks++; if (ov !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL slt_true_flags got ovf %b zero %b want 0 0", ov, z); end
        run_op(CTL_SLT, 32'h1, 32'h8000_0000, r, z, ov, lat, dn);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL slt_false_result got %h want 0", r); end
        checks++; if (ov !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL slt_false_flags got ovf %b zero %b want 0 1", ov, z); end
        run_op(CTL_SLT, 32'h3, 32'h7, r, z, ov, lat, dn);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL slt_small_result got %h want 1", r); end
    endtask

    task automatic test_logic();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        run_op(CTL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z, ov, lat, dn);
        checks++; if (r !== 32'hF000_F000) begin errors++; $display("FAIL and_result got %h want f000f000", r); end
        checks++; if (lat != 33) begin errors++; $display("FAIL and_latency got %0d want 33", lat); end
        run_op(CTL_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z, ov, lat, dn);
        checks++; if (r !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or_result got %h want fff0fff0", r); end
        run_op(CTL_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z, ov, lat, dn);
        checks++; if (r !== 32'h000F_000F) begin errors++; $display("FAIL nor_result got %h want 000f000f", r); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL nor_ovf got %b want 0", ov); end
    endtask

    task automatic test_undefined();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        run_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, ov, lat, dn);
        checks++; if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL undef_outputs got %h/%b/%b want 0/1/0", r, z, ov); end
        checks++; if (lat != 33) begin errors++; $display("FAIL undef_latency got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0; int busy_low = 0; logic [W-1:0] r = '0;
        bus.start = 1'b1; bus.alu_ctl = CTL_ADD; bus.a = 32'd10; bus.b = 32'd20;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 8) begin
                bus.start = 1'b1; bus.alu_ctl = CTL_SUB; bus.a = 32'd100; bus.b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (n <= 33 && bus.busy !== 1'b1) busy_low++;
            if (bus.done === 1'b1) begin pulses++; r = bus.result; end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", pulses); end
        checks++; if (r !== 32'd30) begin errors++; $display("FAIL b2b_result got %h want 0000001e", r); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy got %0d low cycles want 0", busy_low); end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] r; logic z, ov, dn; int lat; int pulses = 0;
        bus.start = 1'b1; bus.alu_ctl = CTL_ADD; bus.a = 32'h1234; bus.b = 32'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_busy_done got %b/%b want 0/0", bus.busy, bus.done); end
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got %h/%b/%b want 0/1/0", bus.result, bus.zero, bus.overflow);
        end
        for (int n = 0; n < 40; n++) begin
            if (bus.done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
        run_op(CTL_ADD, 32'd2, 32'd3, r, z, ov, lat, dn);
        checks++; if (r !== 32'd5 || lat != 33) begin errors++; $display("FAIL abort_then_add got %h lat %0d want 5 lat 33", r, lat); end
    endtask

    task automatic test_reset_with_start();
        logic [W-1:0] r; logic z, ov, dn; int lat;
        rst = 1'b1; bus.start = 1'b1; bus.alu_ctl = CTL_ADD; bus.a = 32'd7; bus.b = 32'd8;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start_dropped got busy %b want 0", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(CTL_SUB, 32'd9, 32'd4, r, z, ov, lat, dn);
        checks++; if (r !== 32'd5 || lat != 33) begin errors++; $display("FAIL rst_ready_sub got %h lat %0d want 5 lat 33", r, lat); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_undefined();
        test_back_to_back();
        test_reset_mid_op();
        test_reset_with_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
